color_receiver: RTL

COLOR_RECEIVER -- requirements
Module: color_receiver

---
 rtl/color_receiver.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/color_receiver.sv
// -----------------------------------------------------------------------------
// color_receiver
//   UART (8N1, LSB first) receiver that assembles three consecutive bytes into
//   one 24-bit {R,G,B} pixel and optionally tracks the pixel's x/y position in
//   an IMG_W x IMG_H frame.
//
//   Optional feature macro: COLOR_RX_COORD_EN
//     defined   -> x/y position counters and frame_done are built
//     undefined -> x, y and frame_done are tied to 0
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (4..65535)
//   IMG_W         pixels per row        (1..256)
//   IMG_H         rows per frame        (1..256)
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   RxD            asynchronous UART line, idle high
//   rgb            last assembled pixel {R,G,B}, held between strobes
//   valid          one-cycle strobe: rgb/x/y carry a new pixel
//   x, y           position of the pixel strobed by valid
//   frame_done     one-cycle strobe with valid for the last pixel of a frame
//   framing_error  one-cycle strobe when a stop bit samples low
//   busy           bit FSM is outside IDLE
// -----------------------------------------------------------------------------
module color_receiver #(
    parameter int CLKS_PER_BIT = 868,
    parameter int IMG_W        = 160,
    parameter int IMG_H        = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RxD,
    output logic [23:0] rgb,
    output logic        valid,
    output logic [7:0]  x,
    output logic [7:0]  y,
    output logic        frame_done,
    output logic        framing_error,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

    state_t      state_reg, state_next;
    logic        rx_meta_reg, rx_s_reg;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic [1:0]  byte_idx_reg, byte_idx_next;
    logic [7:0]  r_reg, r_next;
    logic [7:0]  g_reg, g_next;
    logic [23:0] rgb_reg, rgb_next;
    logic        valid_reg, valid_next;
    logic        ferr_reg, ferr_next;

    // Two-flop synchronizer; flops reset to the idle (high) line level so a
    // reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= RxD;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            byte_idx_reg <= '0;
            r_reg        <= '0;
            g_reg        <= '0;
            rgb_reg      <= '0;
            valid_reg    <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            byte_idx_reg <= byte_idx_next;
            r_reg        <= r_next;
            g_reg        <= g_next;
            rgb_reg      <= rgb_next;
            valid_reg    <= valid_next;
            ferr_reg     <= ferr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        byte_idx_next = byte_idx_reg;
        r_next        = r_reg;
        g_next        = g_reg;
        rgb_next      = rgb_reg;
        valid_next    = 1'b0;
        ferr_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s_reg) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                // Re-check the line half a bit in; a high level means the
                // falling edge was a glitch.
                if (cnt_reg == HALF_END) begin
                    cnt_next = '0;
                    if (rx_s_reg) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            DATA: begin
                if (cnt_reg == BIT_END) begin
                    cnt_next                = '0;
                    shift_next[bit_idx_reg] = rx_s_reg;
                    bit_idx_next            = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            STOP: begin
                // Sampling mid-stop-bit and leaving immediately leaves half a
                // bit of slack to catch a back-to-back start bit.
                if (cnt_reg == BIT_END) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rx_s_reg) begin
                        case (byte_idx_reg)
                            2'd0: begin
                                r_next        = shift_reg;
                                byte_idx_next = 2'd1;
                            end
                            2'd1: begin
                                g_next        = shift_reg;
                                byte_idx_next = 2'd2;
                            end
                            default: begin
                                rgb_next      = {r_reg, g_reg, shift_reg};
                                valid_next    = 1'b1;
                                byte_idx_next = 2'd0;
                            end
                        endcase
                    end else begin
                        // Drop the byte and any partially built pixel.
                        ferr_next     = 1'b1;
                        byte_idx_next = 2'd0;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rgb           = rgb_reg;
    assign valid         = valid_reg;
    assign framing_error = ferr_reg;
    assign busy          = (state_reg != IDLE);

`ifdef COLOR_RX_COORD_EN
    localparam logic [7:0] X_LAST = 8'(IMG_W - 1);
    localparam logic [7:0] Y_LAST = 8'(IMG_H - 1);

    logic [7:0] pos_x_reg, pos_y_reg;
    logic [7:0] x_reg, y_reg;
    logic       fd_reg;

    // pos_* is the position the next pixel will occupy; it is latched into
    // x/y together with valid and then advanced.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x_reg <= '0;
            pos_y_reg <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            fd_reg    <= 1'b0;
        end else begin
            fd_reg <= 1'b0;
            if (valid_next) begin
                x_reg  <= pos_x_reg;
                y_reg  <= pos_y_reg;
                fd_reg <= (pos_x_reg == X_LAST) && (pos_y_reg == Y_LAST);
                if (pos_x_reg == X_LAST) begin
                    pos_x_reg <= '0;
                    pos_y_reg <= (pos_y_reg == Y_LAST) ? 8'd0 : pos_y_reg + 8'd1;
                end else begin
                    pos_x_reg <= pos_x_reg + 8'd1;
                end
            end
        end
    end

    assign x          = x_reg;
    assign y          = y_reg;
    assign frame_done = fd_reg;
`else
    // Frame dimensions only matter for position tracking.
    logic [1:0] unused_dims;
    assign unused_dims = {IMG_W[0], IMG_H[0]};

    assign x          = 8'd0;
    assign y          = 8'd0;
    assign frame_done = 1'b0;
`endif

endmodule
